// File: rtl/audio_pkg.sv
// Shared constants and FSM state type for the stereo DAC serializer.
package audio_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_L = 3'd1,
    ST_DELAY  = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_PAD    = 3'd4
  } ser_state_e;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO; pointers carry the state, storage is not reset.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full       = (count_q == LW'(DEPTH));
  assign empty      = (count_q == '0);
  assign fill_level = count_q;
  assign rdata      = mem_q[rd_ptr_q];
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;

  // Next pointer / occupancy; simultaneous push and pop leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame storage write port.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_serializer_st.sv
// Stereo frame serializer slaved to codec bclk/daclrck, I2S or left-justified.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | disabled, dacdat held 0
// WAIT_L  | enabled, waiting for the first left boundary to start output
// DELAY   | I2S one-bclk gap after a boundary, dacdat 0
// SHIFT   | driving word bits MSB-first, one per bclk fall
// PAD     | word complete, dacdat 0 until the next channel boundary
module audio_serializer_st
  import audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = MODE_I2S
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [2*DATA_W-1:0]             sink_data,
  input  logic                            sink_valid,
  output logic                            sink_ready,
  input  logic                            enable,
  input  logic                            mute,
  input  logic                            underrun_clr,
  input  logic                            bclk,
  input  logic                            daclrck,
  output logic                            dacdat,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int CNT_W   = $clog2(DATA_W);

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [DATA_W-1:0]  word_t;

  ser_state_e state_q, state_d;
  word_t      shreg_q, shreg_d;
  word_t      right_hold_q, right_hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       dacdat_q, dacdat_d;
  logic       underrun_q, underrun_d;
  logic       ready_en_q;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_prev_q;
  logic bfall, lrck_chg, left_bnd, right_bnd;

  frame_t fifo_rdata, pop_frame;
  logic   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic   pop_req, load_req;
  word_t  load_val, word;

  assign sink_ready = ready_en_q && !fifo_full;
  assign fifo_push  = sink_valid && sink_ready;
  assign dacdat     = dacdat_q;
  assign underrun   = underrun_q;

  assign bfall     = bclk_s3_q && !bclk_s2_q;
  assign lrck_chg  = bfall && (lrck_s2_q != lrck_prev_q);
  assign left_bnd  = lrck_chg && !lrck_s2_q;
  assign right_bnd = lrck_chg && lrck_s2_q;

  audio_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .wdata      (sink_data),
    .pop        (fifo_pop),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .fill_level (fill_level)
  );

  // Codec clock synchronisers; lrck is latched on each bclk fall to find boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_prev_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      bclk_s1_q  <= bclk;
      bclk_s2_q  <= bclk_s1_q;
      bclk_s3_q  <= bclk_s2_q;
      lrck_s1_q  <= daclrck;
      lrck_s2_q  <= lrck_s1_q;
      ready_en_q <= 1'b1;
      if (bfall) lrck_prev_q <= lrck_s2_q;
    end
  end

  // Next-state, pop/load decisions and serial output.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    right_hold_d = right_hold_q;
    cnt_d        = cnt_q;
    dacdat_d     = dacdat_q;
    pop_req      = 1'b0;
    load_req     = 1'b0;
    load_val     = '0;
    word         = '0;
    fifo_pop     = 1'b0;
    pop_frame    = fifo_empty ? '0 : fifo_rdata;

    if (!enable) begin
      state_d  = ST_IDLE;
      dacdat_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_WAIT_L;
          dacdat_d = 1'b0;
        end
        ST_WAIT_L: begin
          dacdat_d = 1'b0;
          if (left_bnd) pop_req = 1'b1;
        end
        ST_DELAY, ST_SHIFT, ST_PAD: begin
          if (left_bnd) begin
            pop_req = 1'b1;
          end else if (right_bnd) begin
            load_req = 1'b1;
            load_val = right_hold_q;
          end else if (bfall) begin
            if (state_q == ST_DELAY) begin
              dacdat_d = shreg_q[DATA_W-1];
              shreg_d  = shreg_q << 1;
              cnt_d    = CNT_W'(DATA_W - 1);
              state_d  = ST_SHIFT;
            end else if (state_q == ST_SHIFT) begin
              if (cnt_q == '0) begin
                dacdat_d = 1'b0;
                state_d  = ST_PAD;
              end else begin
                dacdat_d = shreg_q[DATA_W-1];
                shreg_d  = shreg_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
              end
            end else begin
              dacdat_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          dacdat_d = 1'b0;
        end
      endcase
    end

    // An empty pop yields a silent frame; a same-cycle push cannot satisfy it.
    if (pop_req) begin
      fifo_pop     = !fifo_empty;
      load_req     = 1'b1;
      load_val     = pop_frame[FRAME_W-1:DATA_W];
      right_hold_d = pop_frame[DATA_W-1:0];
    end

    if (load_req) begin
      word = mute ? '0 : load_val;
      if (MODE == MODE_LJ) begin
        dacdat_d = word[DATA_W-1];
        shreg_d  = word << 1;
        cnt_d    = CNT_W'(DATA_W - 1);
        state_d  = ST_SHIFT;
      end else begin
        dacdat_d = 1'b0;
        shreg_d  = word;
        state_d  = ST_DELAY;
      end
    end

    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (pop_req && fifo_empty) underrun_d = 1'b1;
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      right_hold_q <= '0;
      cnt_q        <= '0;
      dacdat_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      right_hold_q <= right_hold_d;
      cnt_q        <= cnt_d;
      dacdat_q     <= dacdat_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule
